// File: rtl/ula_pkg.sv
// Shared opcode constants, FSM state type and flag bit positions for the ULA
// sequencer and its flag calculator.
package ula_pkg;

   localparam logic [4:0] OP_SOMA    = 5'b00000;
   localparam logic [4:0] OP_SOMA1   = 5'b00001;
   localparam logic [4:0] OP_INC     = 5'b00011;
   localparam logic [4:0] OP_SUB1    = 5'b00100;
   localparam logic [4:0] OP_SUB     = 5'b00101;
   localparam logic [4:0] OP_DEC     = 5'b00110;
   localparam logic [4:0] OP_SHL     = 5'b01000;
   localparam logic [4:0] OP_SAR     = 5'b01001;
   localparam logic [4:0] OP_ZERO    = 5'b10000;
   localparam logic [4:0] OP_PASSA_A = 5'b10101;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      OCIOSO,
      EXECUTA,
      DESLOCA,
      RESPONDE
   } estado_t;

   function automatic logic eh_opcode_valido(input logic [4:0] op);
      return !((op == 5'b00010) || (op == 5'b00111) ||
               ((op >= 5'b01010) && (op <= 5'b01111)));
   endfunction

   function automatic logic eh_deslocamento(input logic [4:0] op);
      return (op == OP_SHL) || (op == OP_SAR);
   endfunction

endpackage

// File: rtl/ula_calc_flags.sv
// Combinational Z/C/N/O generator; recomputes carry and overflow from the
// operands so the status never depends on the ULA itself.
module ula_calc_flags
   import ula_pkg::*;
#(
   parameter int BITS_PALAVRA = 16
) (
   input  logic [4:0]              op_i,
   input  logic [BITS_PALAVRA:0]   a_i,
   input  logic [BITS_PALAVRA:0]   b_i,
   input  logic [BITS_PALAVRA:0]   result_i,
   input  logic                    carry_desl_i,
   output logic [3:0]              flags_o
);

   logic [BITS_PALAVRA:0]   bEfetivo;
   logic                    cin;
   logic                    aritmetica;
   logic [BITS_PALAVRA+1:0] soma;

   always_comb begin
      bEfetivo   = '0;
      cin        = 1'b0;
      aritmetica = 1'b1;
      unique case (op_i)
         OP_SOMA:  bEfetivo = b_i;
         OP_SOMA1: begin bEfetivo = b_i;  cin = 1'b1; end
         OP_INC:   cin = 1'b1;
         OP_SUB1:  bEfetivo = ~b_i;
         OP_SUB:   begin bEfetivo = ~b_i; cin = 1'b1; end
         OP_DEC:   bEfetivo = '1;
         default:  aritmetica = 1'b0;
      endcase

      soma = {1'b0, a_i} + {1'b0, bEfetivo} + {{(BITS_PALAVRA+1){1'b0}}, cin};

      flags_o         = '0;
      flags_o[FLAG_Z] = (result_i == '0);
      flags_o[FLAG_N] = result_i[BITS_PALAVRA];
      if (aritmetica) begin
         flags_o[FLAG_C] = (soma >> (BITS_PALAVRA + 1)) != '0;
         flags_o[FLAG_O] = (a_i[BITS_PALAVRA] == bEfetivo[BITS_PALAVRA]) &&
                           (result_i[BITS_PALAVRA] != a_i[BITS_PALAVRA]);
      end else if (eh_deslocamento(op_i)) begin
         flags_o[FLAG_C] = carry_desl_i;
      end
   end

endmodule

// File: rtl/ula_sequenciador.sv
// Multi-cycle controller in front of the combinational ULA: one operation per
// handshake, multi-bit shifts as repeated 1-bit passes, registered result/flags.
module ula_sequenciador
   import ula_pkg::*;
#(
   parameter int BITS_PALAVRA  = 16,
   parameter int BITS_CONTROLE = 5,
   parameter int BITS_QTD      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [4:0]               req_op,
   input  logic [BITS_PALAVRA:0]    req_a,
   input  logic [BITS_PALAVRA:0]    req_b,
   input  logic [BITS_QTD-1:0]      req_qtd,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [BITS_PALAVRA:0]    resp_resultado,
   output logic [3:0]               resp_flags,
   output logic                     resp_erro,
   output logic [BITS_PALAVRA:0]    ula_operandoA,
   output logic [BITS_PALAVRA:0]    ula_operandoB,
   output logic [BITS_CONTROLE:0]   ula_controle,
   input  logic [BITS_PALAVRA:0]    ula_resultado
);

   estado_t                 estado_q, estado_d;
   logic [4:0]              op_q, op_d;
   logic [BITS_PALAVRA:0]   a_q, a_d;
   logic [BITS_PALAVRA:0]   b_q, b_d;
   logic [BITS_QTD-1:0]     qtd_q, qtd_d;
   logic [BITS_PALAVRA:0]   resultado_q, resultado_d;
   logic [3:0]              flags_q, flags_d;
   logic                    erro_q, erro_d;

   logic [4:0]              opEfetivo;
   logic [BITS_PALAVRA:0]   ulaA;
   logic [BITS_PALAVRA:0]   ulaB;
   logic                    bitPerdido;
   logic [3:0]              flagsCalc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= OCIOSO;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         qtd_q       <= '0;
         resultado_q <= '0;
         flags_q     <= '0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         qtd_q       <= qtd_d;
         resultado_q <= resultado_d;
         flags_q     <= flags_d;
         erro_q      <= erro_d;
      end
   end

   // a_q doubles as the shift accumulator while in DESLOCA.
   always_comb begin
      estado_d    = estado_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      qtd_d       = qtd_q;
      resultado_d = resultado_q;
      flags_d     = flags_q;
      erro_d      = erro_q;
      opEfetivo   = OP_ZERO;
      ulaA        = '0;
      ulaB        = '0;
      bitPerdido  = 1'b0;

      unique case (estado_q)
         OCIOSO: begin
            if (req_valid) begin
               op_d     = req_op;
               a_d      = req_a;
               b_d      = req_b;
               qtd_d    = req_qtd;
               estado_d = (eh_deslocamento(req_op) && (req_qtd != '0)) ? DESLOCA : EXECUTA;
            end
         end
         EXECUTA: begin
            if (eh_opcode_valido(op_q)) begin
               opEfetivo = eh_deslocamento(op_q) ? OP_PASSA_A : op_q;
               ulaA      = a_q;
               ulaB      = b_q;
            end
            resultado_d = ula_resultado;
            flags_d     = flagsCalc;
            erro_d      = !eh_opcode_valido(op_q);
            estado_d    = RESPONDE;
         end
         DESLOCA: begin
            opEfetivo  = op_q;
            ulaA       = a_q;
            bitPerdido = (op_q == OP_SHL) ? a_q[BITS_PALAVRA] : a_q[0];
            a_d        = ula_resultado;
            qtd_d      = qtd_q - {{(BITS_QTD-1){1'b0}}, 1'b1};
            if (qtd_q == {{(BITS_QTD-1){1'b0}}, 1'b1}) begin
               resultado_d = ula_resultado;
               flags_d     = flagsCalc;
               erro_d      = 1'b0;
               estado_d    = RESPONDE;
            end
         end
         RESPONDE: begin
            if (resp_ready) begin
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   ula_calc_flags #(
      .BITS_PALAVRA (BITS_PALAVRA)
   ) u_calc_flags (
      .op_i         (opEfetivo),
      .a_i          (ulaA),
      .b_i          (ulaB),
      .result_i     (ula_resultado),
      .carry_desl_i (bitPerdido),
      .flags_o      (flagsCalc)
   );

   assign req_ready      = (estado_q == OCIOSO);
   assign resp_valid     = (estado_q == RESPONDE);
   assign resp_resultado = resultado_q;
   assign resp_flags     = flags_q;
   assign resp_erro      = erro_q;
   assign ula_operandoA  = ulaA;
   assign ula_operandoB  = ulaB;
   assign ula_controle   = {{(BITS_CONTROLE-4){1'b0}}, opEfetivo};

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: a behavioural ULA stub plus an
// arithmetic reference model, directed corner cases then random operations.
module tb_ula_sequenciador;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [16:0] req_a;
   logic [16:0] req_b;
   logic [3:0]  req_qtd;
   logic        resp_valid;
   logic        resp_ready;
   logic [16:0] resp_resultado;
   logic [3:0]  resp_flags;
   logic        resp_erro;
   logic [16:0] ula_operandoA;
   logic [16:0] ula_operandoB;
   logic [5:0]  ula_controle;
   logic [16:0] ula_resultado;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ula_sequenciador dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_qtd        (req_qtd),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_resultado (resp_resultado),
      .resp_flags     (resp_flags),
      .resp_erro      (resp_erro),
      .ula_operandoA  (ula_operandoA),
      .ula_operandoB  (ula_operandoB),
      .ula_controle   (ula_controle),
      .ula_resultado  (ula_resultado)
   );

   // Logical/constant half of the ULA operation table (opcodes 1xxxx).
   function automatic logic [16:0] logicFn(input logic [4:0] op, input logic [16:0] x, input logic [16:0] y);
      case (op)
         5'h10:   return 17'h0;
         5'h11:   return x & y;
         5'h12:   return x | y;
         5'h13:   return x ^ y;
         5'h14:   return ~x;
         5'h15:   return x;
         default: return y;
      endcase
   endfunction

   // Combinational ULA stub; garbage on unassigned codes exposes misdriving.
   function automatic logic [16:0] ulaStub(input logic [5:0] c, input logic [16:0] x, input logic [16:0] y);
      if (c[5]) return 17'h1ABCD;
      case (c[4:0])
         5'h00:   return x + y;
         5'h01:   return x + y + 17'd1;
         5'h03:   return x + 17'd1;
         5'h04:   return x + ~y;
         5'h05:   return x - y;
         5'h06:   return x - 17'd1;
         5'h08:   return {x[15:0], 1'b0};
         5'h09:   return {x[16], x[16:1]};
         default: return c[4] ? logicFn(c[4:0], x, y) : 17'h1ABCD;
      endcase
   endfunction

   always_comb ula_resultado = ulaStub(ula_controle, ula_operandoA, ula_operandoB);

   function automatic int sx(input logic [16:0] v);
      return v[16] ? int'(v) - 131072 : int'(v);
   endfunction

   task automatic refModel(input logic [4:0] op, input logic [16:0] a, input logic [16:0] b,
                           input logic [3:0] qtd, output logic [16:0] res, output logic [3:0] fl,
                           output logic err, output int lat);
      logic        c, o, cin, arit;
      logic [16:0] bp;
      longint      us;
      int          ss;
      c = 1'b0; o = 1'b0; cin = 1'b0; arit = 1'b1; bp = '0;
      err = (op == 5'h02) || (op == 5'h07) || ((op >= 5'h0A) && (op <= 5'h0F));
      lat = (((op == 5'h08) || (op == 5'h09)) && (qtd != 0)) ? 1 + int'(qtd) : 2;
      case (op)
         5'h00:   bp = b;
         5'h01:   begin bp = b; cin = 1'b1; end
         5'h03:   cin = 1'b1;
         5'h04:   bp = ~b;
         5'h05:   begin bp = ~b; cin = 1'b1; end
         5'h06:   bp = 17'h1FFFF;
         default: arit = 1'b0;
      endcase
      if (err) begin
         res = '0;
      end else if (arit) begin
         us  = longint'(a) + longint'(bp) + longint'(cin);
         res = us[16:0];
         c   = (us >= 131072);
         ss  = sx(a) + sx(bp) + int'(cin);
         o   = (ss > 65535) || (ss < -65536);
      end else if (op == 5'h08) begin
         res = a << qtd;
         if (qtd != 0) c = a[17 - int'(qtd)];
      end else if (op == 5'h09) begin
         res = 17'($signed(a) >>> qtd);
         if (qtd != 0) c = a[int'(qtd) - 1];
      end else begin
         res = logicFn(op, a, b);
      end
      fl = {(res == 17'h0), c, res[16], o};
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [16:0] eRes, input logic [3:0] eFl, input logic eErr);
      chk({tag, "_resultado"}, resp_resultado, eRes);
      chk({tag, "_flags"}, resp_flags, eFl);
      chk({tag, "_erro"}, resp_erro, eErr);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 1);
   endtask

   task automatic checkReset(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resultado"}, resp_resultado, 0);
      chk({tag, "_flags"}, resp_flags, 0);
      chk({tag, "_erro"}, resp_erro, 0);
      chk({tag, "_opA"}, ula_operandoA, 0);
      chk({tag, "_opB"}, ula_operandoB, 0);
      chk({tag, "_ctrl"}, ula_controle, 6'b010000);
   endtask

   task automatic applyStimulus(input logic [4:0] op, input logic [16:0] a, input logic [16:0] b,
                                input logic [3:0] qtd, input int hold, input logic intruder);
      logic [16:0] eRes;
      logic [3:0]  eFl;
      logic        eErr;
      int          lat;
      int          cyc;
      refModel(op, a, b, qtd, eRes, eFl, eErr, lat);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_qtd = qtd;
      @(negedge clk);
      req_valid = 1'b0; req_op = 5'($urandom); req_a = 17'($urandom);
      req_b = 17'($urandom); req_qtd = 4'($urandom);
      cyc = 1;
      if (eErr) begin
         chk("ula_ctrl_not_illegal", ula_controle[4:0] != op, 1);
      end else begin
         chk("ula_ctrl", ula_controle,
             {1'b0, (((op == 5'h08) || (op == 5'h09)) && (qtd == 0)) ? 5'h15 : op});
         chk("ula_opA", ula_operandoA, a);
      end
      while (!resp_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, lat);
      checkOutput("resp", eRes, eFl, eErr);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (intruder) begin
            req_valid = 1'b1; req_op = 5'($urandom); req_a = 17'($urandom);
         end
         checkOutput("hold", eRes, eFl, eErr);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_valid_after_hs", resp_valid, 0);
      chk("req_ready_after_hs", req_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      req_qtd = '0; resp_ready = 1'b0;
      #3;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed cases");
      applyStimulus(5'h00, 17'h0FFFF, 17'h00001, 4'd0, 0, 1'b0);
      applyStimulus(5'h00, 17'h1FFFF, 17'h00001, 4'd0, 0, 1'b0);
      applyStimulus(5'h08, 17'h10001, 17'h00000, 4'd3, 0, 1'b0);
      applyStimulus(5'h08, 17'h10001, 17'h00000, 4'd1, 1, 1'b0);
      applyStimulus(5'h02, 17'h01234, 17'h00567, 4'd0, 5, 1'b1);
      applyStimulus(5'h05, 17'h00003, 17'h00005, 4'd0, 0, 1'b0);
      applyStimulus(5'h09, 17'h10003, 17'h00000, 4'd0, 0, 1'b0);
      applyStimulus(5'h09, 17'h10003, 17'h00000, 4'd2, 0, 1'b0);

      $display("[TB] reset during shift");
      @(negedge clk);
      req_valid = 1'b1; req_op = 5'h08; req_a = 17'h00001; req_qtd = 4'd15;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("shift_pass4_ctrl", ula_controle, 6'b001000);
      #2 rst_n = 1'b0;
      #1 checkReset("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'h01, 17'h00010, 17'h00020, 4'd0, 0, 1'b0);

      $display("[TB] random cases");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(5'($urandom_range(0, 31)), 17'($urandom), 17'($urandom),
                       4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
- Multi-cycle controller that sits between the instruction-decode logic and the combinational ULA (ALU).
- Accepts one operation per request/response handshake and drives the ULA operand and control inputs.
- Runs multi-bit shifts as repeated 1-bit ULA shift passes, one pass per cycle.
- Registers the result and computes the Z/C/N/O status flags itself.

Parameters:
- BITS_PALAVRA, 16: MSB index of the data path. All operand and result buses are [BITS_PALAVRA:0], i.e. 17 bits, two's complement.
- BITS_CONTROLE, 5: MSB index of the ULA control bus, i.e. [BITS_CONTROLE:0].
- BITS_QTD, 4: width of the shift-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  5  ULA operation code (binary encoding of the ULA operation table).
- req_a  in  BITS_PALAVRA+1  operand A.
- req_b  in  BITS_PALAVRA+1  operand B.
- req_qtd  in  BITS_QTD  shift count; used only for ops 01000 and 01001.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_resultado  out  BITS_PALAVRA+1  registered result.
- resp_flags  out  4  {Z,C,N,O}, registered.
- resp_erro  out  1  the request used an unassigned opcode.
- ula_operandoA  out  BITS_PALAVRA+1  to ULA operand A.
- ula_operandoB  out  BITS_PALAVRA+1  to ULA operand B.
- ula_controle  out  BITS_CONTROLE+1  to ULA control; driven as {1'b0, op}.
- ula_resultado  in  BITS_PALAVRA+1  from ULA result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FSM in OCIOSO; req_ready=1; resp_valid=0; resp_resultado=0; resp_flags=0; resp_erro=0; ula_operandoA=0; ula_operandoB=0; ula_controle=6'b010000 (the constant-0 op). A reset asserted mid-operation aborts the operation immediately, with no response.
- FSM states: OCIOSO, EXECUTA, DESLOCA, RESPONDE.
- OCIOSO:
  - req_ready=1.
  - On req_valid, latch op, a, b and qtd (cycle t).
  - Next state: DESLOCA if op is a shift and qtd>0; otherwise EXECUTA.
- EXECUTA (cycle t+1):
  - Drive ULA with the latched a, b and op.
  - Capture ula_resultado and the flags into the response registers.
  - Go to RESPONDE. resp_valid=1 from cycle t+2.
- DESLOCA:
  - Accumulator acc is initialised to a. Each cycle: drive ula_operandoA=acc with the shift op; acc<=ula_resultado; C<=bit lost (acc[16] for 01000, acc[0] for 01001); counter decrements.
  - After qtd passes, go to RESPONDE. resp_valid from cycle t+1+qtd.
- Shift with qtd=0: executed in EXECUTA as op 10101 (pass A). Result=a, C=0.
- RESPONDE:
  - Outputs held stable until resp_ready=1, then return to OCIOSO.
  - req_ready=0 in every state except OCIOSO, so there is no overlap: the next request is accepted at the earliest one cycle after the response handshake.
- Flags, computed by the ula_calc_flags sub-module:
  - Z = (result==0). N = result[16].
  - Arithmetic ops are evaluated as A + B' + cin over 18 bits, with:
    - 00000: B'=B, cin=0.
    - 00001: B'=B, cin=1.
    - 00011: B'=0, cin=1.
    - 00100: B'=~B, cin=0.
    - 00101: B'=~B, cin=1.
    - 00110: B'=all-ones, cin=0.
  - For arithmetic ops: C = bit 17 of that sum. O = (A[16]==B'[16]) && (result[16]!=A[16]).
  - Shifts: C = last bit lost, O=0.
  - Logical and constant ops: C=0, O=0.
- Unassigned opcodes (00010, 00111, 01010-01111):
  - The ULA is not driven with the opcode.
  - resp_resultado=0, flags={1,0,0,0}, resp_erro=1. Latency is the same as EXECUTA.
  - resp_erro is 0 for every legal opcode.
- The result is always taken from ula_resultado, so the ULA path is exercised; flags never come from the ULA.

Decomposition:
- Package ula_pkg:
  - Opcode localparams (OP_SOMA, OP_SOMA1, OP_INC, OP_SUB1, OP_SUB, OP_DEC, OP_SHL, OP_SAR, OP_ZERO, OP_PASSA_A, ...).
  - State enum estado_t.
  - Flag index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0.
  - Function eh_opcode_valido().
- Sub-module ula_calc_flags: combinational; inputs op, a, b, result and shift carry; outputs {Z,C,N,O}.

Test Plan:
- Add overflow: op 00000, a=17'h0FFFF, b=17'h00001 → result 17'h10000, flags Z0 C0 N1 O1, resp_valid 2 cycles after acceptance.
- Add carry: op 00000, a=17'h1FFFF, b=17'h00001 → result 0, flags Z1 C1 N0 O0.
- Logical shift left: op 01000, a=17'h10001, qtd=3 → three ULA passes; result 17'h00008, C=0; resp_valid at t+4. Same op with qtd=1 → result 17'h00002, C=1.
- Arithmetic shift right: op 01001, a=17'h10003, qtd=2 → result 17'h1C000, flags Z0 C1 N1 O0.
- Illegal op and backpressure:
  - op 00010 → resp_erro=1, result 0, Z=1.
  - Hold resp_ready=0 for 5 cycles → outputs stable, req_ready=0 throughout, a second req_valid is ignored until after the handshake.
- Reset mid-shift: qtd=15, assert rst_n=0 at pass 4 → all outputs return to reset values asynchronously; the next request completes normally.
